// File: rtl/cam_pkg.sv
// Shared definitions for the bit-plane CAM subarray.
//   OP_*      : cmd_op encodings
//   state_t   : controller states (ST_IDLE, ST_SRCH)
//   row_width : row address width for a given row count
package cam_pkg;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SEARCH = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SRCH = 1'b1
    } state_t;

    function automatic int row_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/cam_row_cmp.sv
// Combinational compare of one stored bit-plane row against one key bit.
// Optional macro CAM_TERNARY_EN adds a care vector; care = 0 forces a match.
//   row_bits : stored row (one bit per column)
//   key_bit  : key bit broadcast across all columns
//   care     : per-column compare enable (CAM_TERNARY_EN only)
//   match    : 1 where the column matches
module cam_row_cmp #(
    parameter int COLS = 32
) (
    input  logic [COLS-1:0] row_bits,
    input  logic            key_bit,
`ifdef CAM_TERNARY_EN
    input  logic [COLS-1:0] care,
`endif
    output logic [COLS-1:0] match
);

`ifdef CAM_TERNARY_EN
    assign match = ~(row_bits ^ {COLS{key_bit}}) | ~care;
`else
    assign match = ~(row_bits ^ {COLS{key_bit}});
`endif

endmodule

// File: rtl/cam_bitplane_subarray.sv
// Bit-plane CAM subarray: ROWS x COLS cells, each column one stored word.
// Masked row write, row read, and bit-serial search over KEY_W consecutive
// rows producing a per-column tag vector (replace or AND-accumulate).
// Optional macro CAM_TERNARY_EN adds a care plane and the wr_care port.
// Ports:
//   CLK, rst            : clock (rising), async active-low reset
//   cmd_valid/cmd_ready : command handshake, ready only in IDLE
//   cmd_op, cmd_row     : operation and target/base row
//   wr_data, wr_mask    : write data and per-column write enable
//   wr_care             : care bits for writes (CAM_TERNARY_EN only)
//   key, acc_en         : search key and accumulate select
//   tag_clr             : clears tag_out
//   tag_out, tag_valid  : search result and landing pulse
//   rd_data, rd_valid   : read result and pulse
//   err                 : pulse on an out-of-range command
module cam_bitplane_subarray
    import cam_pkg::*;
#(
    parameter int ROWS  = 36,
    parameter int COLS  = 32,
    parameter int KEY_W = 2,
    parameter int ROW_W = row_width(ROWS)
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [ROW_W-1:0] cmd_row,
    input  logic [COLS-1:0]  wr_data,
    input  logic [COLS-1:0]  wr_mask,
`ifdef CAM_TERNARY_EN
    input  logic [COLS-1:0]  wr_care,
`endif
    input  logic [KEY_W-1:0] key,
    input  logic             acc_en,
    input  logic             tag_clr,
    output logic [COLS-1:0]  tag_out,
    output logic             tag_valid,
    output logic [COLS-1:0]  rd_data,
    output logic             rd_valid,
    output logic             err
);

    localparam int CNT_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_W - 1);

    state_t           state;
    logic [ROW_W-1:0] base_q;
    logic [KEY_W-1:0] key_q;
    logic             acc_q;
    logic [CNT_W-1:0] cnt;
    logic [COLS-1:0]  match_q;
    logic [COLS-1:0]  mem [ROWS];
`ifdef CAM_TERNARY_EN
    logic [COLS-1:0]  care_mem [ROWS];
`endif

    logic             accept;
    logic             row_bad;
    logic [ROW_W-1:0] srch_row;
    logic [COLS-1:0]  row_match;
    logic [COLS-1:0]  final_match;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign srch_row  = base_q + ROW_W'(cnt);

    always_comb begin
        row_bad = (int'(cmd_row) >= ROWS);
        if (cmd_op == OP_SEARCH && (int'(cmd_row) + KEY_W > ROWS))
            row_bad = 1'b1;
    end

    cam_row_cmp #(.COLS(COLS)) u_cmp (
        .row_bits (mem[srch_row]),
        .key_bit  (key_q[cnt]),
`ifdef CAM_TERNARY_EN
        .care     (care_mem[srch_row]),
`endif
        .match    (row_match)
    );

    assign final_match = match_q & row_match;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            base_q    <= '0;
            key_q     <= '0;
            acc_q     <= 1'b0;
            cnt       <= '0;
            match_q   <= '1;
            tag_out   <= '0;
            tag_valid <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            err       <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                mem[r] <= '0;
`ifdef CAM_TERNARY_EN
                care_mem[r] <= '1;
`endif
            end
        end else begin
            tag_valid <= 1'b0;
            rd_valid  <= 1'b0;
            err       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tag_clr)
                        tag_out <= '0;
                    if (accept) begin
                        if (row_bad) begin
                            err <= 1'b1;
                        end else begin
                            case (cmd_op)
                                OP_WRITE: begin
                                    mem[cmd_row] <= (mem[cmd_row] & ~wr_mask) | (wr_data & wr_mask);
`ifdef CAM_TERNARY_EN
                                    care_mem[cmd_row] <= (care_mem[cmd_row] & ~wr_mask) | (wr_care & wr_mask);
`endif
                                end
                                OP_READ: begin
                                    rd_data  <= mem[cmd_row];
                                    rd_valid <= 1'b1;
                                end
                                OP_SEARCH: begin
                                    base_q  <= cmd_row;
                                    key_q   <= key;
                                    acc_q   <= acc_en;
                                    cnt     <= '0;
                                    match_q <= '1;
                                    state   <= ST_SRCH;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_SRCH: begin
                    if (cnt == CNT_LAST) begin
                        // A clear on the final edge zeroes the accumulate base.
                        tag_out   <= (acc_q && !tag_clr) ? (tag_out & final_match) : final_match;
                        tag_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        match_q <= final_match;
                        cnt     <= cnt + 1'b1;
                        if (tag_clr)
                            tag_out <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_bitplane_subarray.sv
module tb_cam_bitplane_subarray;

    localparam int ROWS  = 36;
    localparam int COLS  = 32;
    localparam int KEY_W = 2;

    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [5:0]  cmd_row = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] wr_mask = '0;
    logic [1:0]  key = '0;
    logic        acc_en = 1'b0;
    logic        tag_clr = 1'b0;
    logic [31:0] tag_out;
    logic        tag_valid;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    cam_bitplane_subarray #(.ROWS(ROWS), .COLS(COLS), .KEY_W(KEY_W)) dut (
        .CLK       (CLK),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_row   (cmd_row),
        .wr_data   (wr_data),
        .wr_mask   (wr_mask),
`ifdef CAM_TERNARY_EN
        .wr_care   ('1),
`endif
        .key       (key),
        .acc_en    (acc_en),
        .tag_clr   (tag_clr),
        .tag_out   (tag_out),
        .tag_valid (tag_valid),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .err       (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [ROWS];
    logic [31:0] m_tag, m_rd, s_res;
    logic        m_tv, m_rv, m_err, s_acc;
    int          m_busy;

    // Column c matches when every key bit equals the stored bit in its row.
    function automatic logic [31:0] search_ref(input int base, input logic [1:0] k);
        logic [31:0] r;
        for (int c = 0; c < COLS; c++) begin
            r[c] = 1'b1;
            for (int i = 0; i < KEY_W; i++)
                if (m_mem[base + i][c] != k[i]) r[c] = 1'b0;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++) m_mem[r] = '0;
        m_tag = '0; m_rd = '0; m_tv = 0; m_rv = 0; m_err = 0; m_busy = 0;
        s_res = '0; s_acc = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge rst);
            if (!rst) begin
                model_reset();
            end else begin
                m_tv = 0; m_rv = 0; m_err = 0;
                if (m_busy > 0) begin
                    m_busy--;
                    if (m_busy == 0) begin
                        m_tag = (s_acc && !tag_clr) ? (m_tag & s_res) : s_res;
                        m_tv  = 1;
                    end else if (tag_clr) begin
                        m_tag = '0;
                    end
                end else begin
                    if (tag_clr) m_tag = '0;
                    if (cmd_valid) begin
                        if (int'(cmd_row) >= ROWS || (cmd_op == 2'b10 && int'(cmd_row) + KEY_W > ROWS)) begin
                            m_err = 1;
                        end else if (cmd_op == 2'b01) begin
                            for (int c = 0; c < COLS; c++)
                                if (wr_mask[c]) m_mem[cmd_row][c] = wr_data[c];
                        end else if (cmd_op == 2'b11) begin
                            m_rd = m_mem[cmd_row];
                            m_rv = 1;
                        end else if (cmd_op == 2'b10) begin
                            s_res  = search_ref(int'(cmd_row), key);
                            s_acc  = acc_en;
                            m_busy = KEY_W;
                        end
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        chk("cmd_ready", 32'(cmd_ready), 32'(m_busy == 0));
        chk("tag_out",   tag_out,        m_tag);
        chk("tag_valid", 32'(tag_valid), 32'(m_tv));
        chk("rd_data",   rd_data,        m_rd);
        chk("rd_valid",  32'(rd_valid),  32'(m_rv));
        chk("err",       32'(err),       32'(m_err));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] row, input logic [31:0] d,
                         input logic [31:0] m, input logic [1:0] k, input logic acc);
        cmd_valid = 1; cmd_op = op; cmd_row = row; wr_data = d; wr_mask = m; key = k; acc_en = acc;
        step();
        cmd_valid = 0; cmd_op = 2'b00;
    endtask

    initial begin
        step(); step(); step();
        rst = 1;
        step();
        chk("reset tag_out", tag_out, 32'h0);
        chk("reset ready", 32'(cmd_ready), 32'h1);

        issue(2'b11, 6'd5, '0, '0, 2'b00, 0);
        chk("read5 rd_valid", 32'(rd_valid), 32'h1);
        chk("read5 rd_data", rd_data, 32'h0);
        step();
        chk("read5 rd_valid drop", 32'(rd_valid), 32'h0);

        issue(2'b01, 6'd4, 32'hF0F0_00FF, '1, 2'b00, 0);
        issue(2'b01, 6'd5, 32'hFF00_0F0F, '1, 2'b00, 0);
        issue(2'b10, 6'd4, '0, '0, 2'b11, 0);
        chk("srch busy1", 32'(cmd_ready), 32'h0);
        step();
        chk("srch busy2", 32'(cmd_ready), 32'h0);
        chk("srch no early tv", 32'(tag_valid), 32'h0);
        step();
        chk("srch tag_valid", 32'(tag_valid), 32'h1);
        chk("srch ready back", 32'(cmd_ready), 32'h1);
        chk("srch key11", tag_out, 32'hF000_000F);

        issue(2'b10, 6'd4, '0, '0, 2'b01, 1);
        step(); step();
        chk("srch acc", tag_out, 32'h0000_0000);

        issue(2'b10, 6'd4, '0, '0, 2'b01, 1);
        step();
        tag_clr = 1;
        step();
        tag_clr = 0;
        chk("srch acc clr", tag_out, 32'h00F0_00F0);

        issue(2'b10, 6'd35, '0, '0, 2'b11, 0);
        chk("srch35 err", 32'(err), 32'h1);
        chk("srch35 ready", 32'(cmd_ready), 32'h1);
        step();
        chk("srch35 no tv", 32'(tag_valid), 32'h0);
        chk("srch35 tag", tag_out, 32'h00F0_00F0);
        issue(2'b11, 6'd36, '0, '0, 2'b00, 0);
        chk("read36 err", 32'(err), 32'h1);
        chk("read36 no rv", 32'(rd_valid), 32'h0);

        issue(2'b01, 6'd4, 32'h0, 32'h0000_FFFF, 2'b00, 0);
        issue(2'b11, 6'd4, '0, '0, 2'b00, 0);
        chk("partial write", rd_data, 32'hF0F0_0000);

        issue(2'b10, 6'd4, '0, '0, 2'b00, 0);
        step();
        rst = 0;
        step();
        chk("abort tag", tag_out, 32'h0);
        chk("abort tv", 32'(tag_valid), 32'h0);
        step();
        chk("abort tv later", 32'(tag_valid), 32'h0);
        rst = 1;
        step();
        chk("post rst ready", 32'(cmd_ready), 32'h1);
        issue(2'b11, 6'd4, '0, '0, 2'b00, 0);
        chk("post rst read", rd_data, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_row   = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(34, 63)) : 6'($urandom_range(0, 7));
            wr_data   = $urandom;
            wr_mask   = $urandom;
            key       = 2'($urandom_range(0, 3));
            acc_en    = 1'($urandom_range(0, 1));
            tag_clr   = ($urandom_range(0, 7) == 0);
            if (i == 1500) rst = 0;
            if (i == 1502) rst = 1;
            step();
        end
        cmd_valid = 0; tag_clr = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cam_bitplane_subarray.md
Name: cam_bitplane_subarray

Overview:
- Parametrised successor to the fixed 36x32 CAM subarray used by the FP CAM top level.
- Stores ROWS x COLS bit cells, one bit-plane per row. Each column is one stored word.
- Supports masked row writes, row reads, and multi-cycle bit-serial search over KEY_W consecutive rows.
- Produces a per-column tag vector. Tags can replace the previous result or AND-accumulate into it; the sign, exponent and mantissa subarrays combine results this way.

Parameters:
- ROWS, 36, number of bit-plane rows.
- COLS, 32, number of columns (stored words); also the tag width.
- KEY_W, 2, key bits compared per SEARCH, one row per cycle; must satisfy 1 <= KEY_W <= ROWS.
- ROW_W, $clog2(ROWS), row address width (derived).

Ports:
- CLK  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 NOP, 01 WRITE, 10 SEARCH, 11 READ.
- cmd_row  in  ROW_W  target row (WRITE/READ) or base row (SEARCH).
- wr_data  in  COLS  WRITE data.
- wr_mask  in  COLS  WRITE bit enable; 1 = write that column.
- key  in  KEY_W  SEARCH key; key[i] is compared against row cmd_row+i.
- acc_en  in  1  sampled at SEARCH accept; 1 = AND the result into tag_out.
- tag_clr  in  1  clears tag_out to 0.
- tag_out  out  COLS  registered tag vector.
- tag_valid  out  1  one-cycle pulse when a SEARCH result lands.
- rd_data  out  COLS  registered READ data.
- rd_valid  out  1  one-cycle pulse, cycle after READ accept.
- err  out  1  one-cycle pulse on an illegal command.

Behaviour:
- Reset (rst low, asynchronous):
  - all memory cells = 0; state = IDLE.
  - tag_out = 0, rd_data = 0, tag_valid = 0, rd_valid = 0, err = 0.
  - cmd_ready = 1 (combinational from state == IDLE).
- Handshake: a command is accepted on a rising edge where cmd_valid and cmd_ready are both high. NOP is accepted and has no effect.
- WRITE:
  - On the accept edge: mem[cmd_row][c] = wr_data[c] for every c with wr_mask[c] = 1; other columns hold.
  - State stays IDLE, so back-to-back writes run every cycle.
- READ:
  - On the accept edge, rd_data loads mem[cmd_row]; rd_valid = 1 for the following cycle.
  - State stays IDLE.
  - A READ after a WRITE to the same row in the previous cycle returns the new data.
- SEARCH:
  - The accept edge latches base row, key and acc_en; cnt = 0; state goes to SRCH.
  - On each SRCH edge k (k = 0..KEY_W-1): match &= (mem[base+k] XNOR {COLS{key[k]}}); match starts all-ones.
  - On the edge with k = KEY_W-1: tag_out = acc ? (tag_out & final_match) : final_match. Then tag_valid = 1 for one cycle and state returns to IDLE.
  - Latency is KEY_W cycles from accept to the tag_valid cycle. cmd_ready is low throughout SRCH and high again in the tag_valid cycle.
- Illegal commands:
  - Row bound: cmd_row >= ROWS (any op), or SEARCH with cmd_row+KEY_W > ROWS.
  - Response: the command is consumed, err = 1 for the next cycle, and memory, tag_out and state are unchanged.
- tag_clr:
  - In IDLE, tag_out = 0 on that edge.
  - If asserted on the final SRCH edge, the accumulated base is treated as 0, so tag_out = final_match regardless of acc.
  - During a non-final SRCH cycle it clears tag_out immediately.
- No partial results: reset mid-SEARCH aborts the operation and no tag_valid is produced.
- State machine: IDLE -(SEARCH accepted, legal)-> SRCH -(cnt = KEY_W-1)-> IDLE. There are no other states.

Optional Feature:
- Macro: CAM_TERNARY_EN.
- Defined:
  - Adds a care plane of ROWS x COLS bits (reset to 1) and an input wr_care[COLS].
  - WRITE also updates care bits under wr_mask.
  - In SEARCH, a cell with care = 0 always matches.
  - READ returns data only.
- Undefined: no care plane, no wr_care port; every cell is compared.

Decomposition:
- Package cam_pkg holds:
  - the cmd_op encoding localparams (OP_NOP, OP_WRITE, OP_SEARCH, OP_READ);
  - the state enum (ST_IDLE, ST_SRCH);
  - a row-width helper function.
- One sub-module, cam_row_cmp: combinational COLS-wide compare of one row against one key bit, with care input under CAM_TERNARY_EN, producing a match vector.

Test Plan (ROWS=36, COLS=32, KEY_W=2):
- Reset, then READ row 5 -> rd_valid pulses one cycle after accept, rd_data = 0x0000_0000, tag_out = 0.
- WRITE row 4 = 0xF0F0_00FF and row 5 = 0xFF00_0F0F (mask all ones); SEARCH row 4, key 2'b11, acc_en = 0 -> tag_valid 2 cycles after accept, tag_out = 0xF000_000F, cmd_ready low for exactly 2 cycles.
- Continue with SEARCH row 4, key 2'b01, acc_en = 1 (row4 = 1, row5 = 0 -> 0x00F0_00F0) -> tag_out = 0x0000_0000. Repeat with tag_clr on the final cycle -> tag_out = 0x00F0_00F0.
- SEARCH at row 35, and READ at row 36 -> err pulses each time, tag_out unchanged, cmd_ready stays 1, no tag_valid.
- WRITE row 4 data 0 with mask 0x0000_FFFF, then READ row 4 -> rd_data = 0xF0F0_0000.
- SEARCH accepted, rst driven low one cycle later -> no tag_valid, tag_out = 0, memory all 0. After release, cmd_ready = 1 and a READ of row 4 returns 0.
